// File: rtl/router_reg_param.sv
`default_nettype none
// ============================================================================
// Module   : router_reg_param
// Brief    : Router packet register: header latch, payload/parity streaming to
//            the output FIFO, running XOR parity, hold buffer for FIFO-full.
// Revision : 1.0  initial release
// ============================================================================
module router_reg_param #(
    parameter int DATA_WIDTH = 8,
    parameter int HOLD_DEPTH = 2,
    parameter int CHECK_LEN  = 1
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic                            pkt_valid,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            fifo_full,
    input  logic                            detect_add,
    input  logic                            lfd_state,
    input  logic                            ld_state,
    input  logic                            laf_state,
    input  logic                            rst_int_reg,
    output logic [DATA_WIDTH-1:0]           dout,
    output logic                            dout_wr,
    output logic                            parity_done,
    output logic                            low_pkt_valid,
    output logic                            err,
    output logic                            len_err,
    output logic [$clog2(HOLD_DEPTH+1)-1:0] hold_count,
    output logic                            hold_empty,
    output logic                            hold_ovf
);

    localparam int C_CNT_W = $clog2(HOLD_DEPTH + 1);
    localparam int C_PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
    localparam int C_LEN_W = DATA_WIDTH - 2;

    logic [DATA_WIDTH-1:0] r_hdr;
    logic [DATA_WIDTH-1:0] r_int_par;
    logic [DATA_WIDTH-1:0] r_pkt_par;
    logic [C_LEN_W-1:0]    r_len_cnt;
    logic                  r_chk;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_wr;
    logic                  r_parity_done;
    logic                  r_low_pkt_valid;
    logic                  r_err;
    logic                  r_len_err;
    logic                  r_hold_ovf;

    logic [DATA_WIDTH-1:0] r_mem [HOLD_DEPTH];
    logic [C_PTR_W-1:0]    r_rd_ptr;
    logic [C_PTR_W-1:0]    r_wr_ptr;
    logic [C_CNT_W-1:0]    r_cnt;

    logic                  w_hold_empty;
    logic                  w_hold_full;
    logic                  w_hdr_cap;
    logic                  w_par_set;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_dout_nxt;

    function automatic logic [C_PTR_W-1:0] f_next_ptr(input logic [C_PTR_W-1:0] p);
        return (p == C_PTR_W'(HOLD_DEPTH - 1)) ? '0 : p + C_PTR_W'(1);
    endfunction

    assign w_hold_empty = (r_cnt == '0);
    assign w_hold_full  = (r_cnt == C_CNT_W'(HOLD_DEPTH));
    assign w_hdr_cap    = pkt_valid && detect_add;
    // Only the first low-pkt_valid byte of a packet is the parity byte.
    assign w_par_set    = ld_state && !pkt_valid && !r_parity_done;

    // Write-path selection; when the FIFO accepts and bytes are held, the
    // head goes out first and the incoming byte joins the tail.
    always_comb begin
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_drop     = 1'b0;
        w_wr       = 1'b0;
        w_dout_nxt = r_dout;
        if (lfd_state) begin
            w_wr       = 1'b1;
            w_dout_nxt = r_hdr;
        end else if (ld_state) begin
            if (!fifo_full) begin
                w_wr = 1'b1;
                if (w_hold_empty) begin
                    w_dout_nxt = data_in;
                end else begin
                    w_dout_nxt = r_mem[r_rd_ptr];
                    w_pop      = 1'b1;
                    w_push     = 1'b1;
                end
            end else if (w_hold_full) begin
                w_drop = 1'b1;
            end else begin
                w_push = 1'b1;
            end
        end else if (laf_state && !fifo_full && !w_hold_empty) begin
            w_wr       = 1'b1;
            w_pop      = 1'b1;
            w_dout_nxt = r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_dout    <= '0;
            r_dout_wr <= 1'b0;
        end else begin
            r_dout    <= w_dout_nxt;
            r_dout_wr <= w_wr;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < HOLD_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_in;
                r_wr_ptr        <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + C_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - C_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_hdr     <= '0;
            r_int_par <= '0;
            r_pkt_par <= '0;
            r_len_cnt <= '0;
            r_chk     <= 1'b0;
        end else begin
            r_chk <= w_par_set;
            if (w_hdr_cap) begin
                r_hdr     <= data_in;
                r_int_par <= '0;
                r_pkt_par <= '0;
                r_len_cnt <= '0;
            end else if (lfd_state) begin
                r_int_par <= r_hdr;
            end else if (ld_state && pkt_valid) begin
                r_int_par <= r_int_par ^ data_in;
                if (r_len_cnt != {C_LEN_W{1'b1}}) begin
                    r_len_cnt <= r_len_cnt + C_LEN_W'(1);
                end
            end else if (w_par_set) begin
                r_pkt_par <= data_in;
            end
        end
    end

    // Clears come first so that same-cycle sets take priority.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_parity_done   <= 1'b0;
            r_low_pkt_valid <= 1'b0;
            r_err           <= 1'b0;
            r_len_err       <= 1'b0;
            r_hold_ovf      <= 1'b0;
        end else begin
            if (w_hdr_cap || rst_int_reg) begin
                r_parity_done <= 1'b0;
                r_err         <= 1'b0;
                r_len_err     <= 1'b0;
                r_hold_ovf    <= 1'b0;
            end
            if (rst_int_reg) begin
                r_low_pkt_valid <= 1'b0;
            end
            if (ld_state && !pkt_valid) begin
                r_low_pkt_valid <= 1'b1;
            end
            if (w_par_set) begin
                r_parity_done <= 1'b1;
            end
            if (r_chk) begin
                r_err     <= (r_int_par != r_pkt_par);
                r_len_err <= (CHECK_LEN != 0) && (r_len_cnt != r_hdr[DATA_WIDTH-1:2]);
            end
            if (w_drop) begin
                r_hold_ovf <= 1'b1;
            end
        end
    end

    assign dout          = r_dout;
    assign dout_wr       = r_dout_wr;
    assign parity_done   = r_parity_done;
    assign low_pkt_valid = r_low_pkt_valid;
    assign err           = r_err;
    assign len_err       = r_len_err;
    assign hold_count    = r_cnt;
    assign hold_empty    = w_hold_empty;
    assign hold_ovf      = r_hold_ovf;

endmodule
`default_nettype wire

// File: tb/tb_router_reg_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_reg_param
// Brief    : Directed bench for router_reg_param (default and CHECK_LEN=0).
// Revision : 1.0  initial release
// ============================================================================
module tb_router_reg_param;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       rst_int_reg;

    logic [7:0] dout;
    logic       dout_wr;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;
    logic       len_err;
    logic [1:0] hold_count;
    logic       hold_empty;
    logic       hold_ovf;

    logic [7:0] nl_dout;
    logic       nl_dout_wr;
    logic       nl_parity_done;
    logic       nl_low_pkt_valid;
    logic       nl_err;
    logic       nl_len_err;
    logic [1:0] nl_hold_count;
    logic       nl_hold_empty;
    logic       nl_hold_ovf;

    int errors = 0;
    int checks = 0;

    router_reg_param #(.DATA_WIDTH(8), .HOLD_DEPTH(2), .CHECK_LEN(1)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
        .dout(dout), .dout_wr(dout_wr), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .err(err), .len_err(len_err),
        .hold_count(hold_count), .hold_empty(hold_empty), .hold_ovf(hold_ovf)
    );

    router_reg_param #(.DATA_WIDTH(8), .HOLD_DEPTH(2), .CHECK_LEN(0)) dut_nl (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
        .dout(nl_dout), .dout_wr(nl_dout_wr), .parity_done(nl_parity_done),
        .low_pkt_valid(nl_low_pkt_valid), .err(nl_err), .len_err(nl_len_err),
        .hold_count(nl_hold_count), .hold_empty(nl_hold_empty), .hold_ovf(nl_hold_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        pkt_valid   = 1'b0;
        data_in     = 8'h00;
        fifo_full   = 1'b0;
        detect_add  = 1'b0;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        rst_int_reg = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        clr_in();
    endtask

    task automatic do_hdr(input logic [7:0] b);
        pkt_valid = 1'b1; detect_add = 1'b1; data_in = b;
        tick();
    endtask

    task automatic do_lfd();
        lfd_state = 1'b1; pkt_valid = 1'b1;
        tick();
    endtask

    task automatic do_ld(input logic [7:0] b, input logic pv, input logic ff);
        ld_state = 1'b1; data_in = b; pkt_valid = pv; fifo_full = ff;
        tick();
    endtask

    task automatic do_laf(input logic ff);
        laf_state = 1'b1; fifo_full = ff;
        tick();
    endtask

    task automatic do_rst_int();
        rst_int_reg = 1'b1;
        tick();
    endtask

    initial begin
        clr_in();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_dout", 32'(dout), 0);
        chk("rst_dout_wr", 32'(dout_wr), 0);
        chk("rst_parity_done", 32'(parity_done), 0);
        chk("rst_low_pkt_valid", 32'(low_pkt_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_len_err", 32'(len_err), 0);
        chk("rst_hold_count", 32'(hold_count), 0);
        chk("rst_hold_empty", 32'(hold_empty), 1);
        chk("rst_hold_ovf", 32'(hold_ovf), 0);
        @(negedge clock);
        resetn = 1'b1;
        tick();

        // Normal packet: 0D, 11, 22, 33, parity 0D
        do_hdr(8'h0D);
        chk("n_hdr_no_wr", 32'(dout_wr), 0);
        do_lfd();
        chk("n_dout_hdr", 32'(dout), 32'h0D);
        chk("n_wr_hdr", 32'(dout_wr), 1);
        do_ld(8'h11, 1'b1, 1'b0);
        chk("n_dout_11", 32'(dout), 32'h11);
        do_ld(8'h22, 1'b1, 1'b0);
        chk("n_dout_22", 32'(dout), 32'h22);
        do_ld(8'h33, 1'b1, 1'b0);
        chk("n_dout_33", 32'(dout), 32'h33);
        chk("n_wr_33", 32'(dout_wr), 1);
        do_ld(8'h0D, 1'b0, 1'b0);
        chk("n_dout_par", 32'(dout), 32'h0D);
        chk("n_parity_done", 32'(parity_done), 1);
        chk("n_low_pkt_valid", 32'(low_pkt_valid), 1);
        tick();
        chk("n_idle_wr", 32'(dout_wr), 0);
        chk("n_idle_dout_hold", 32'(dout), 32'h0D);
        chk("n_err", 32'(err), 0);
        chk("n_len_err", 32'(len_err), 0);
        do_rst_int();
        chk("n_clr_parity_done", 32'(parity_done), 0);
        chk("n_clr_low_pkt_valid", 32'(low_pkt_valid), 0);

        // Bad parity
        do_hdr(8'h0D);
        do_lfd();
        do_ld(8'h11, 1'b1, 1'b0);
        do_ld(8'h22, 1'b1, 1'b0);
        do_ld(8'h33, 1'b1, 1'b0);
        do_ld(8'h0E, 1'b0, 1'b0);
        chk("b_parity_done", 32'(parity_done), 1);
        chk("b_err_not_yet", 32'(err), 0);
        tick();
        chk("b_err_set", 32'(err), 1);
        tick();
        chk("b_err_sticky", 32'(err), 1);
        do_rst_int();
        chk("b_err_clr", 32'(err), 0);

        // Length mismatch: header 11 says 4 bytes, 3 sent
        do_hdr(8'h11);
        do_lfd();
        chk("l_dout_hdr", 32'(dout), 32'h11);
        do_ld(8'h11, 1'b1, 1'b0);
        do_ld(8'h22, 1'b1, 1'b0);
        do_ld(8'h33, 1'b1, 1'b0);
        do_ld(8'h11, 1'b0, 1'b0);
        tick();
        chk("l_len_err", 32'(len_err), 1);
        chk("l_err", 32'(err), 0);
        chk("l_nocheck_len_err", 32'(nl_len_err), 0);
        chk("l_nocheck_err", 32'(nl_err), 0);
        do_rst_int();
        chk("l_len_err_clr", 32'(len_err), 0);

        // FIFO full while byte 22 is presented
        do_hdr(8'h0D);
        do_lfd();
        do_ld(8'h11, 1'b1, 1'b0);
        do_ld(8'h22, 1'b1, 1'b1);
        chk("f_hold_count", 32'(hold_count), 1);
        chk("f_hold_empty", 32'(hold_empty), 0);
        chk("f_no_wr", 32'(dout_wr), 0);
        chk("f_dout_kept", 32'(dout), 32'h11);
        do_laf(1'b0);
        chk("f_laf_dout", 32'(dout), 32'h22);
        chk("f_laf_wr", 32'(dout_wr), 1);
        chk("f_laf_empty", 32'(hold_empty), 1);
        do_ld(8'h33, 1'b1, 1'b0);
        chk("f_dout_33", 32'(dout), 32'h33);
        do_ld(8'h0D, 1'b0, 1'b0);
        chk("f_dout_par", 32'(dout), 32'h0D);
        tick();
        chk("f_err", 32'(err), 0);
        do_rst_int();

        // Overflow: three bytes while full, depth 2
        do_hdr(8'h0D);
        do_lfd();
        do_ld(8'h11, 1'b1, 1'b1);
        chk("o_cnt1", 32'(hold_count), 1);
        do_ld(8'h22, 1'b1, 1'b1);
        chk("o_cnt2", 32'(hold_count), 2);
        chk("o_no_ovf_yet", 32'(hold_ovf), 0);
        do_ld(8'h33, 1'b1, 1'b1);
        chk("o_cnt_sat", 32'(hold_count), 2);
        chk("o_ovf", 32'(hold_ovf), 1);
        chk("o_no_wr", 32'(dout_wr), 0);
        do_ld(8'h0D, 1'b0, 1'b0);
        chk("o_pushpop_dout", 32'(dout), 32'h11);
        chk("o_pushpop_cnt", 32'(hold_count), 2);
        do_laf(1'b0);
        chk("o_laf1_dout", 32'(dout), 32'h22);
        chk("o_laf1_cnt", 32'(hold_count), 1);
        do_laf(1'b0);
        chk("o_laf2_dout", 32'(dout), 32'h0D);
        chk("o_laf2_empty", 32'(hold_empty), 1);
        do_laf(1'b0);
        chk("o_laf_empty_no_wr", 32'(dout_wr), 0);
        chk("o_ovf_sticky", 32'(hold_ovf), 1);
        do_rst_int();
        chk("o_ovf_clr", 32'(hold_ovf), 0);

        // Reset mid-packet
        do_hdr(8'h0D);
        do_lfd();
        do_ld(8'h11, 1'b1, 1'b1);
        do_ld(8'h22, 1'b1, 1'b0);
        chk("r_pre_dout", 32'(dout), 32'h11);
        chk("r_pre_cnt", 32'(hold_count), 1);
        resetn = 1'b0;
        #1;
        chk("r_dout", 32'(dout), 0);
        chk("r_dout_wr", 32'(dout_wr), 0);
        chk("r_hold_count", 32'(hold_count), 0);
        chk("r_hold_empty", 32'(hold_empty), 1);
        chk("r_low_pkt_valid", 32'(low_pkt_valid), 0);
        @(negedge clock);
        resetn = 1'b1;
        tick();
        do_hdr(8'h0D);
        do_lfd();
        chk("r2_dout_hdr", 32'(dout), 32'h0D);
        do_ld(8'h11, 1'b1, 1'b0);
        chk("r2_dout_11", 32'(dout), 32'h11);
        do_ld(8'h22, 1'b1, 1'b0);
        do_ld(8'h33, 1'b1, 1'b0);
        do_ld(8'h0D, 1'b0, 1'b0);
        chk("r2_parity_done", 32'(parity_done), 1);
        tick();
        chk("r2_err", 32'(err), 0);
        chk("r2_len_err", 32'(len_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
